// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts exceptions, MRET and machine interrupts from write-back,
// then serialises the CSR updates and a PC redirect. Optional macro: TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_pc_i,
    input  logic        exc_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_tval_i,
    input  logic        xret_i,
    input  logic        xint_meip_i,
    input  logic        xint_msip_i,
    input  logic        xint_mtip_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        take_o,
    output logic        stall_o,
    output logic        csr_we_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, cause_q, cause_d, tval_q, tval_d;
    logic [31:0] mstat_q, mstat_d, tgt_q, tgt_d;
    logic        xret_q, xret_d;
    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;

    logic        irq_mei, irq_msi, irq_mti, irq_any, take;
    logic [3:0]  irq_code;
    logic [31:0] base, mstat_new;
    logic        unused_bits;

    assign unused_bits = &{1'b0, mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};

    assign irq_mei  = mstatus_i[3] & xint_meip_i & mie_i[11];
    assign irq_msi  = mstatus_i[3] & xint_msip_i & mie_i[3];
    assign irq_mti  = mstatus_i[3] & xint_mtip_i & mie_i[7];
    assign irq_any  = irq_mei | irq_msi | irq_mti;
    assign irq_code = irq_mei ? 4'd11 : (irq_msi ? 4'd3 : 4'd7);
    assign take     = (state_q == IDLE) & wb_valid_i & (exc_i | xret_i | irq_any);
    assign base     = {mtvec_i[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        mstat_d = mstat_q;
        tgt_d   = tgt_q;
        xret_d  = xret_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    pc_d    = wb_pc_i;
                    mstat_d = mstatus_i;
                    xret_d  = ~exc_i & xret_i;
                    if (exc_i) begin
                        cause_d = {28'b0, exc_cause_i};
                        tval_d  = exc_tval_i;
                        tgt_d   = base;
                    end else if (xret_i) begin
                        cause_d = cause_q;
                        tval_d  = tval_q;
                        tgt_d   = mepc_i;
                    end else begin
                        cause_d = {1'b1, 27'b0, irq_code};
                        tval_d  = 32'h0;
`ifdef TRAP_VECTORED_EN
                        tgt_d   = (mtvec_i[1:0] == 2'b01) ? base + {26'b0, irq_code, 2'b00} : base;
`else
                        tgt_d   = base;
`endif
                    end
                    state_d = (~exc_i & xret_i) ? W_MSTAT : W_MEPC;
                end
            end
            W_MEPC:   state_d = W_MCAUSE;
            W_MCAUSE: state_d = W_MTVAL;
            W_MTVAL:  state_d = W_MSTAT;
            W_MSTAT:  state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // New mstatus: MIE/MPIE swap direction depends on trap vs return; MPP forced to M.
    always_comb begin
        mstat_new        = mstat_d;
        mstat_new[12:11] = 2'b11;
        if (xret_d) begin
            mstat_new[3] = mstat_d[7];
            mstat_new[7] = 1'b1;
        end else begin
            mstat_new[7] = mstat_d[3];
            mstat_new[3] = 1'b0;
        end
    end

    // Write port is registered, so it is decoded from the state being entered.
    always_comb begin
        csr_we_d    = 1'b0;
        csr_addr_d  = 12'h000;
        csr_wdata_d = 32'h0;
        case (state_d)
            W_MEPC:   begin csr_we_d = 1'b1; csr_addr_d = 12'h341; csr_wdata_d = pc_d;      end
            W_MCAUSE: begin csr_we_d = 1'b1; csr_addr_d = 12'h342; csr_wdata_d = cause_d;   end
            W_MTVAL:  begin csr_we_d = 1'b1; csr_addr_d = 12'h343; csr_wdata_d = tval_d;    end
            W_MSTAT:  begin csr_we_d = 1'b1; csr_addr_d = 12'h300; csr_wdata_d = mstat_new; end
            default:  begin csr_we_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pc_q        <= 32'h0;
            cause_q     <= 32'h0;
            tval_q      <= 32'h0;
            mstat_q     <= 32'h0;
            tgt_q       <= 32'h0;
            xret_q      <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= 12'h000;
            csr_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            mstat_q     <= mstat_d;
            tgt_q       <= tgt_d;
            xret_q      <= xret_d;
            csr_we_q    <= csr_we_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
        end
    end

    assign take_o        = rst_i & take;
    assign stall_o       = take_o | (state_q != IDLE);
    assign csr_we_o      = csr_we_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_wdata_o   = csr_wdata_q;
    assign redirect_o    = (state_q == REDIRECT);
    assign redirect_pc_o = (state_q == REDIRECT) ? tgt_q : RESET_PC;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed cases plus random transactions against a rule-level model.
module tb_trap_ctrl;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i, exc_i, xret_i, xint_meip_i, xint_msip_i, xint_mtip_i;
    logic [31:0] wb_pc_i, exc_tval_i, mstatus_i, mie_i, mtvec_i, mepc_i;
    logic [3:0]  exc_cause_i;
    logic        take_o, stall_o, csr_we_o, redirect_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, redirect_pc_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] obs_mcause, obs_mstat, obs_rpc;

    trap_ctrl #(.RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
        .exc_i(exc_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i), .xret_i(xret_i),
        .xint_meip_i(xint_meip_i), .xint_msip_i(xint_msip_i), .xint_mtip_i(xint_mtip_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .take_o(take_o), .stall_o(stall_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
        .csr_wdata_o(csr_wdata_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        wb_valid_i = 0; wb_pc_i = 0; exc_i = 0; exc_cause_i = 0; exc_tval_i = 0; xret_i = 0;
        xint_meip_i = 0; xint_msip_i = 0; xint_mtip_i = 0;
        mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
    endtask

    task automatic scramble();
        wb_valid_i  = ($urandom_range(3) != 0);
        wb_pc_i     = $urandom; exc_i = $urandom_range(1); exc_cause_i = 4'($urandom);
        exc_tval_i  = $urandom; xret_i = $urandom_range(1);
        xint_meip_i = $urandom_range(1); xint_msip_i = $urandom_range(1); xint_mtip_i = $urandom_range(1);
        mstatus_i   = $urandom; mie_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
    endtask

    // Reference: what the architectural rules say this cycle's inputs should cause.
    task automatic model(output bit acc, output bit xr, output logic [31:0] ca,
                         output logic [31:0] tv, output logic [31:0] ms, output logic [31:0] tg);
        int code;
        bit vec;
        acc = 0; xr = 0; ca = 0; tv = 0; ms = 0; tg = 0; code = -1;
        if (!wb_valid_i) return;
        if (!exc_i && !xret_i && mstatus_i[3]) begin
            if (xint_meip_i && mie_i[11])      code = 11;
            else if (xint_msip_i && mie_i[3])  code = 3;
            else if (xint_mtip_i && mie_i[7])  code = 7;
        end
        if (!exc_i && !xret_i && code < 0) return;
        acc = 1;
        if (!exc_i && xret_i) begin
            xr = 1;
            ms = (mstatus_i & ~32'h1888) | 32'h1880 | (mstatus_i[7] ? 32'h8 : 32'h0);
            tg = mepc_i;
            return;
        end
        ms = (mstatus_i & ~32'h1888) | 32'h1800 | (mstatus_i[3] ? 32'h80 : 32'h0);
        tg = mtvec_i & ~32'h3;
        if (exc_i) begin
            ca = 32'(exc_cause_i);
            tv = exc_tval_i;
        end else begin
            ca = 32'h8000_0000 + 32'(code);
            tv = 0;
`ifdef TRAP_VECTORED_EN
            vec = 1;
`else
            vec = 0;
`endif
            if (vec && mtvec_i[1:0] == 2'b01) tg = tg + 32'(4 * code);
        end
    endtask

    // Applies the inputs currently driven for one IDLE cycle and follows any resulting sequence.
    task automatic run_txn();
        bit acc, xr;
        logic [31:0] ca, tv, ms, tg, pc;
        logic [11:0] ea;
        logic [31:0] ed;
        int n;
        model(acc, xr, ca, tv, ms, tg);
        pc = wb_pc_i;
        @(negedge clk_i);
        check("take", take_o, acc);
        check("stall_t", stall_o, acc);
        check("we_idle", csr_we_o, 0);
        check("redir_idle", redirect_o, 0);
        check("rpc_idle", redirect_pc_o, RPC);
        if (acc) begin
            n = xr ? 2 : 5;
            for (int k = 1; k <= n; k++) begin
                @(posedge clk_i); #1;
                scramble();
                @(negedge clk_i);
                check("stall_busy", stall_o, 1);
                check("take_busy", take_o, 0);
                if (k < n) begin
                    if (xr || k == 4) begin ea = 12'h300; ed = ms; end
                    else if (k == 1)  begin ea = 12'h341; ed = pc; end
                    else if (k == 2)  begin ea = 12'h342; ed = ca; end
                    else              begin ea = 12'h343; ed = tv; end
                    check("we", csr_we_o, 1);
                    check("addr", 32'(csr_addr_o), 32'(ea));
                    check("wdata", csr_wdata_o, ed);
                    check("redir_wr", redirect_o, 0);
                    if (csr_addr_o == 12'h342) obs_mcause = csr_wdata_o;
                    if (csr_addr_o == 12'h300) obs_mstat = csr_wdata_o;
                end else begin
                    check("we_redir", csr_we_o, 0);
                    check("redir", redirect_o, 1);
                    check("rpc", redirect_pc_o, tg);
                    obs_rpc = redirect_pc_o;
                end
            end
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_i = 0;
        set_idle();
        obs_mcause = 0; obs_mstat = 0; obs_rpc = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_take", take_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_we", csr_we_o, 0);
        check("rst_addr", 32'(csr_addr_o), 0);
        check("rst_wdata", csr_wdata_o, 0);
        check("rst_redir", redirect_o, 0);
        check("rst_rpc", redirect_pc_o, RPC);
        rst_i = 1;
        @(posedge clk_i); #1;

        // Illegal instruction
        set_idle();
        wb_valid_i = 1; wb_pc_i = 32'h100; exc_i = 1; exc_cause_i = 2; exc_tval_i = 32'h13;
        mtvec_i = 32'h200; mstatus_i = 32'h8;
        run_txn();
        check("ill_mcause", obs_mcause, 32'h2);
        check("ill_mstat", obs_mstat, 32'h1880);
        check("ill_rpc", obs_rpc, 32'h200);

        // MRET, then an immediately idle cycle
        set_idle();
        wb_valid_i = 1; xret_i = 1; mstatus_i = 32'h80; mepc_i = 32'h104;
        run_txn();
        check("mret_mstat", obs_mstat, 32'h1888);
        check("mret_rpc", obs_rpc, 32'h104);
        set_idle();
        @(negedge clk_i);
        check("mret_stall_after", stall_o, 0);
        @(posedge clk_i); #1;

        // Interrupt priority
        set_idle();
        wb_valid_i = 1; xint_meip_i = 1; xint_msip_i = 1; xint_mtip_i = 1;
        mstatus_i = 32'h8; mie_i = 32'h888; mtvec_i = 32'h200;
        run_txn();
        check("prio_mei", obs_mcause, 32'h8000_000B);
        set_idle();
        wb_valid_i = 1; xint_meip_i = 1; xint_msip_i = 1; xint_mtip_i = 1;
        mstatus_i = 32'h8; mie_i = 32'h080; mtvec_i = 32'h200;
        run_txn();
        check("prio_mti", obs_mcause, 32'h8000_0007);

        // Masking: global MIE clear, then no valid instruction
        for (int i = 0; i < 20; i++) begin
            set_idle();
            wb_valid_i = 1; xint_meip_i = 1; mie_i = 32'h888; mstatus_i = 32'h0;
            run_txn();
        end
        for (int i = 0; i < 20; i++) begin
            set_idle();
            wb_valid_i = 0; xint_meip_i = 1; mie_i = 32'h888; mstatus_i = 32'h8;
            run_txn();
        end

        // Timer interrupt with mode bits 01
        set_idle();
        wb_valid_i = 1; xint_mtip_i = 1; mie_i = 32'h080; mstatus_i = 32'h8; mtvec_i = 32'h201;
        run_txn();
`ifdef TRAP_VECTORED_EN
        check("vec_rpc", obs_rpc, 32'h21C);
`else
        check("vec_rpc", obs_rpc, 32'h200);
`endif

        // Exception and MRET together
        set_idle();
        obs_mcause = 32'hDEAD_BEEF;
        wb_valid_i = 1; exc_i = 1; xret_i = 1; exc_cause_i = 5; mtvec_i = 32'h300; mstatus_i = 32'h8;
        run_txn();
        check("conflict_mcause", obs_mcause, 32'h5);

        // Reset dropped during the mcause write
        set_idle();
        wb_valid_i = 1; exc_i = 1; exc_cause_i = 4; wb_pc_i = 32'h40; mtvec_i = 32'h200;
        @(negedge clk_i);
        check("rstmid_take", take_o, 1);
        @(posedge clk_i); #1;
        set_idle();
        @(posedge clk_i); #1;
        check("rstmid_addr", 32'(csr_addr_o), 32'h342);
        rst_i = 0;
        #1;
        check("rstmid_we", csr_we_o, 0);
        check("rstmid_stall", stall_o, 0);
        check("rstmid_redir", redirect_o, 0);
        check("rstmid_rpc", redirect_pc_o, RPC);
        @(posedge clk_i); #1;
        rst_i = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("rstpost_we", csr_we_o, 0);
            check("rstpost_stall", stall_o, 0);
        end
        @(posedge clk_i); #1;

        // Random transactions
        for (int t = 0; t < 200; t++) begin
            scramble();
            run_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
